// File: rtl/latch_seq_pkg.sv
// Shared types for the latch write sequencer: FSM state encoding and the
// phase-counter width helper.
package latch_seq_pkg;

  typedef enum logic [2:0] {
    StInitPre = 3'd0,
    StIdle    = 3'd1,
    StPreset  = 3'd2,
    StSetup   = 3'd3,
    StPulse   = 3'd4,
    StHold    = 3'd5
  } state_e;

  // Wide enough to hold the longest phase length minus one; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/latch_write_seq_if.sv
// Write handshake between upstream logic and the latch sequencer.
interface latch_write_seq_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             WR_VALID;
  logic [WIDTH-1:0] WR_DATA;
  logic             WR_READY;

  modport master (output WR_VALID, output WR_DATA, input WR_READY);
  modport slave  (input WR_VALID, input WR_DATA, output WR_READY);

endinterface

// File: rtl/latch_seq_timer.sv
// Loadable down-counter with a zero flag; times every phase of the sequencer.
module latch_seq_timer #(
  parameter int unsigned CntW = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  output logic            zero_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/latch_write_seq.sv
// Sequencer driving a transparent latch bank (D, gate, gate enable, preset) with
// programmable setup/pulse/hold spacing, plus a shadow copy of the latched value.
module latch_write_seq
  import latch_seq_pkg::*;
#(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  INIT      = {WIDTH{1'b1}},
  parameter int unsigned       SETUP_CYC = 1,
  parameter int unsigned       PULSE_CYC = 2,
  parameter int unsigned       HOLD_CYC  = 1
) (
  input  logic                 C,
  input  logic                 CLR_N,
  latch_write_seq_if.slave     wr,
  input  logic                 PRESET_REQ,
  output logic [WIDTH-1:0]     LD,
  output logic                 LG,
  output logic                 LGE,
  output logic                 LPRE,
  output logic [WIDTH-1:0]     RB_DATA,
  output logic                 BUSY
);

  if (WIDTH < 1 || SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_params
    $error("latch_write_seq: WIDTH and all *_CYC parameters must be >= 1");
  end

  localparam int unsigned CntW = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam logic [CntW-1:0] SetupLd = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0] PulseLd = CntW'(PULSE_CYC - 1);
  localparam logic [CntW-1:0] HoldLd  = CntW'(HOLD_CYC - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ld_q, ld_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic             lg_q, lg_d;
  logic             lge_q, lge_d;
  logic             lpre_q, lpre_d;
  logic             pend_q, pend_d;
  logic             tmr_load;
  logic [CntW-1:0]  tmr_val;
  logic             tmr_zero;

  latch_seq_timer #(
    .CntW (CntW)
  ) u_timer (
    .clk_i      (C),
    .rst_ni     (CLR_N),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    ld_d     = ld_q;
    rb_d     = rb_q;
    lg_d     = lg_q;
    lge_d    = lge_q;
    lpre_d   = lpre_q;
    // Requests seen mid-sequence are remembered; the running sequence always completes.
    pend_d   = pend_q | (PRESET_REQ & (state_q != StIdle));
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      StInitPre: begin
        // First cycle after reset only arms the preset pulse.
        if (!lpre_q) begin
          lpre_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = PulseLd;
        end else if (tmr_zero) begin
          lpre_d  = 1'b0;
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (PRESET_REQ || pend_q) begin
          state_d  = StPreset;
          pend_d   = 1'b0;
          ld_d     = INIT;
          lpre_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = PulseLd;
        end else if (wr.WR_VALID) begin
          state_d  = StSetup;
          ld_d     = wr.WR_DATA;
          tmr_load = 1'b1;
          tmr_val  = SetupLd;
        end
      end
      StSetup: begin
        if (tmr_zero) begin
          state_d  = StPulse;
          lg_d     = 1'b1;
          lge_d    = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = PulseLd;
        end
      end
      StPulse: begin
        if (tmr_zero) begin
          state_d  = StHold;
          lg_d     = 1'b0;
          lge_d    = 1'b0;
          rb_d     = ld_q;
          tmr_load = 1'b1;
          tmr_val  = HoldLd;
        end
      end
      StHold: begin
        if (tmr_zero) state_d = StIdle;
      end
      StPreset: begin
        if (tmr_zero) begin
          state_d = StIdle;
          lpre_d  = 1'b0;
          rb_d    = INIT;
        end
      end
      default: begin
        state_d = StInitPre;
        lg_d    = 1'b0;
        lge_d   = 1'b0;
        lpre_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= StInitPre;
      ld_q    <= INIT;
      rb_q    <= INIT;
      lg_q    <= 1'b0;
      lge_q   <= 1'b0;
      lpre_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      rb_q    <= rb_d;
      lg_q    <= lg_d;
      lge_q   <= lge_d;
      lpre_q  <= lpre_d;
      pend_q  <= pend_d;
    end
  end

  assign LD          = ld_q;
  assign LG          = lg_q;
  assign LGE         = lge_q;
  assign LPRE        = lpre_q;
  assign RB_DATA     = rb_q;
  assign BUSY        = (state_q != StIdle);
  assign wr.WR_READY = (state_q == StIdle) && !PRESET_REQ && !pend_q;

endmodule
